// File: rtl/cache_refill_sched.sv
// Round-robin cache line refill scheduler driving a pipelined read-only downstream port.
// Optional critical-word-first issue order is enabled by defining CACHE_REFILL_CWF_EN.
module cache_refill_sched #(
  parameter int NREQ       = 2,
  parameter int LINE_WORDS = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WW        = $clog2(LINE_WORDS)
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*30-1:0]   i_req_addr,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_busy,
  output logic                 o_rvalid,
  output logic [IDW-1:0]       o_rid,
  output logic [WW-1:0]        o_rword,
  output logic [31:0]          o_rdata,
  output logic                 o_rlast,
  output logic                 o_sel,
  output logic [29:0]          o_addr,
  input  logic [31:0]          i_rdata,
  input  logic                 i_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [WW-1:0]  LAST_WORD = WW'(LINE_WORDS - 1);
  localparam logic [IDW-1:0] LAST_REQ  = IDW'(NREQ - 1);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     winner_q, winner_d;
  logic [29:0]        base_q, base_d;
  logic [WW-1:0]      start_q, start_d;
  logic [WW-1:0]      issue_cnt_q, issue_cnt_d;
  logic [WW-1:0]      recv_cnt_q, recv_cnt_d;
  logic               pend_q, pend_d;
  logic [WW-1:0]      pend_word_q, pend_word_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               rvalid_q, rvalid_d;
  logic [IDW-1:0]     rid_q, rid_d;
  logic [WW-1:0]      rword_q, rword_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rlast_q, rlast_d;

  logic               found;
  logic [IDW-1:0]     win;
  logic [29:0]        win_addr;
  logic [WW-1:0]      issue_word;
  logic               accept;
  logic               beat;

  // Word index wraps within the line and never carries into the base bits.
  assign issue_word = start_q + issue_cnt_q;
  assign o_sel      = (state_q == ISSUE);
  assign o_addr     = o_sel ? (base_q | 30'(issue_word)) : '0;
  assign accept     = o_sel & i_ready;
  assign beat       = pend_q & i_ready;

  // Round-robin search upward from the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + int'(i)) % NREQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    win_addr = i_req_addr[30*int'(win) +: 30];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    base_d      = base_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    gnt_d       = '0;
    rvalid_d    = 1'b0;
    rid_d       = rid_q;
    rword_d     = rword_q;
    rdata_d     = rdata_q;
    rlast_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          gnt_d[win]  = 1'b1;
          winner_d    = win;
          base_d      = {win_addr[29:WW], {WW{1'b0}}};
`ifdef CACHE_REFILL_CWF_EN
          start_d     = win_addr[WW-1:0];
`else
          start_d     = '0;
`endif
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_WORD) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat && (recv_cnt_q == LAST_WORD)) begin
          state_d = IDLE;
          ptr_d   = (winner_q == LAST_REQ) ? '0 : winner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // At most one address is outstanding: a new acceptance replaces the
    // completing one in the same cycle since both need i_ready.
    if (beat) begin
      rvalid_d   = 1'b1;
      rdata_d    = i_rdata;
      rid_d      = winner_q;
      rword_d    = pend_word_q;
      rlast_d    = (recv_cnt_q == LAST_WORD);
      recv_cnt_d = recv_cnt_q + 1'b1;
    end
    if (accept) begin
      pend_d      = 1'b1;
      pend_word_d = issue_word;
    end else if (beat) begin
      pend_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rword_q     <= '0;
      rdata_q     <= '0;
      rlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rword_q     <= rword_d;
      rdata_q     <= rdata_d;
      rlast_q     <= rlast_d;
    end
  end

  assign o_gnt    = gnt_q;
  assign o_busy   = busy_q;
  assign o_rvalid = rvalid_q;
  assign o_rid    = rid_q;
  assign o_rword  = rword_q;
  assign o_rdata  = rdata_q;
  assign o_rlast  = rlast_q;

endmodule
